// File: rtl/memShare_config_pkg.sv
// Shared memShare configuration: word widths, GP2 address space and IB-LUT loader states.
package memShare_config_pkg;
  localparam int QUAN_SIZE          = 4;
  localparam int GP2_COL_SEL_WIDTH  = 1;
  localparam int GP2_RAM_ADDR_WIDTH = GP2_COL_SEL_WIDTH + QUAN_SIZE;
  localparam int IB_LOAD_DEPTH      = 2 ** GP2_RAM_ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    LOAD,
    FLUSH,
    DONE
  } memshare_load_state_t;
endpackage

// File: rtl/memshare_iblut_loader.sv
// Streams IB-LUT entries into the VN rank remap write port; one cycle from accepted beat to write.
// Holds remap enable asserted (low) for the load window; ready is killed combinationally by abort.
module memshare_iblut_loader #(
  parameter int QUAN_SIZE  = memShare_config_pkg::QUAN_SIZE,
  parameter int ADDR_WIDTH = memShare_config_pkg::GP2_RAM_ADDR_WIDTH,
  parameter int LOAD_DEPTH = memShare_config_pkg::IB_LOAD_DEPTH
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic                  abort_i,
  input  logic [QUAN_SIZE-1:0]  lut_data_i,
  input  logic                  lut_valid_i,
  output logic                  lut_ready_o,
  output logic [ADDR_WIDTH-1:0] remap_addr_o,
  output logic [QUAN_SIZE-1:0]  remap_data_o,
  output logic                  remap_we_o,
  output logic                  remap_en_n_o,
  output logic                  busy_o,
  output logic                  load_done_o
);
  import memShare_config_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_DEPTH - 1);

  memshare_load_state_t  state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [QUAN_SIZE-1:0]  data_q, data_d;
  logic                  we_q, we_d;
  logic                  rdy_q, rdy_d;
  logic                  en_n_q, en_n_d;
  logic                  accept;
  logic                  in_window;

  assign lut_ready_o  = rdy_q && !abort_i;
  assign accept       = lut_valid_i && lut_ready_o && (state_q == LOAD);
  assign in_window    = (state_q == ARM) || (state_q == LOAD) || (state_q == FLUSH);
  assign remap_addr_o = addr_q;
  assign remap_data_o = data_q;
  assign remap_we_o   = we_q;
  assign remap_en_n_o = en_n_q;
  assign busy_o       = (state_q != IDLE);
  assign load_done_o  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE:  if (load_start_i) state_d = ARM;
      ARM: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (accept) begin
          addr_d = cnt_q;
          data_d = lut_data_i;
          we_d   = 1'b1;
          // Stop on the final address so the counter can never wrap into a stray write.
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && in_window) begin
      state_d = IDLE;
      cnt_d   = '0;
      we_d    = 1'b0;
    end
    rdy_d  = (state_d == LOAD);
    en_n_d = !((state_d == ARM) || (state_d == LOAD) || (state_d == FLUSH));
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      en_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      en_n_q  <= en_n_d;
    end
  end
endmodule

// File: tb/tb_memshare_iblut_loader.sv
// Bench for memshare_iblut_loader: full-depth and depth-1 instances against a load-timeline model.
module tb_memshare_iblut_loader;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_start = 1'b0;
  logic       abort = 1'b0;
  logic       lut_valid = 1'b0;
  logic [3:0] lut_data = '0;
  logic       sel = 1'b0;

  logic       rdy0, we0, enn0, busy0, done0, rdy1, we1, enn1, busy1, done1;
  logic [4:0] addr0, addr1;
  logic [3:0] dat0, dat1;

  always #5 sys_clk = ~sys_clk;

  memshare_iblut_loader dut0 (
    .sys_clk(sys_clk), .rst(rst), .load_start_i(load_start && !sel), .abort_i(abort),
    .lut_data_i(lut_data), .lut_valid_i(lut_valid), .lut_ready_o(rdy0),
    .remap_addr_o(addr0), .remap_data_o(dat0), .remap_we_o(we0),
    .remap_en_n_o(enn0), .busy_o(busy0), .load_done_o(done0)
  );

  memshare_iblut_loader #(.LOAD_DEPTH(1)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .load_start_i(load_start && sel), .abort_i(abort),
    .lut_data_i(lut_data), .lut_valid_i(lut_valid), .lut_ready_o(rdy1),
    .remap_addr_o(addr1), .remap_data_o(dat1), .remap_we_o(we1),
    .remap_en_n_o(enn1), .busy_o(busy1), .load_done_o(done1)
  );

  // Model: t = cycles since the accepted start (-1 when idle), n = beats taken, tl = cycle of last beat.
  int         t = -1, n = 0, tl = -1, depth = 32;
  logic       m_we = 1'b0;
  logic [4:0] m_addr = '0;
  logic [3:0] m_data = '0;
  int         wcount = 0;
  int         n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d n=%0d)", tag, obs, exp, t, n);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [3:0] d, input logic a, input logic r);
    logic done_now, e_ready, acc;
    load_start = s; lut_valid = v; lut_data = d; abort = a; rst = r;
    #1;
    done_now = (tl >= 0) && (t == tl + 2);
    e_ready  = (t >= 2) && (tl < 0) && !a;
    chk("ready", sel ? rdy1  : rdy0,  e_ready);
    chk("we",    sel ? we1   : we0,   m_we);
    chk("addr",  sel ? addr1 : addr0, m_addr);
    chk("data",  sel ? dat1  : dat0,  m_data);
    chk("en_n",  sel ? enn1  : enn0,  !((t >= 1) && !done_now));
    chk("busy",  sel ? busy1 : busy0, t >= 0);
    chk("done",  sel ? done1 : done0, done_now);
    if (sel ? we1 : we0) wcount++;
    @(posedge sys_clk);
    if (r) begin
      t = -1; n = 0; tl = -1; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (t < 0) begin
      m_we = 1'b0;
      if (s) begin t = 1; n = 0; tl = -1; end
    end else if (a && !done_now) begin
      t = -1; m_we = 1'b0;
    end else begin
      acc  = e_ready && v;
      m_we = acc;
      if (acc) begin
        m_addr = n[4:0];
        m_data = d;
        n++;
        if (n == depth) tl = t;
      end
      if (done_now) t = -1;
      else t++;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge sys_clk);
    #1;
    step(0, 0, 4'h0, 0, 1);
    step(0, 0, 4'h0, 0, 0);

    // Continuous load, data = addr ^ A
    wcount = 0;
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, n[3:0] ^ 4'hA, 0, 0);
    chk("s1_writes", wcount, 32);

    // Alternating valid
    wcount = 0;
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 120; i++) begin
      if (t < 0) break;
      step(0, (i % 2) == 0, 4'($urandom), 0, 0);
    end
    step(0, 0, 4'h0, 0, 0);
    chk("s2_writes", wcount, 32);

    // Abort on the 10th LOAD cycle
    wcount = 0;
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (t < 0) break;
      step(0, 1, 4'($urandom), t == 11, 0);
    end
    step(0, 1, 4'h3, 0, 0);
    step(0, 0, 4'h0, 0, 0);
    chk("s3_writes", wcount, 9);

    // Start pulses in LOAD and DONE are ignored; next start begins at addr 0
    wcount = 0;
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      if (t < 0) break;
      step((t == 5) || ((tl >= 0) && (t == tl + 2)), 1'($urandom), 4'($urandom), 0, 0);
    end
    step(0, 0, 4'h0, 0, 0);
    chk("s4_writes", wcount, 32);
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 4'($urandom), 0, 0);

    // Randomized loads with occasional aborts and spurious starts
    for (int l = 0; l < 4; l++) begin
      step(1, 0, 4'h0, 0, 0);
      for (int i = 0; i < 150; i++) begin
        if (t < 0) break;
        step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
             $urandom_range(0, 79) == 0, 0);
      end
      step(0, 0, 4'h0, 0, 0);
    end

    // Reset mid-load at cnt = 20
    wcount = 0;
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (n == 20) break;
      step(0, 1, 4'($urandom), 0, 0);
    end
    step(0, 1, 4'h5, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 4'h5, 0, 0);

    // Depth-1 instance
    sel = 1'b1;
    depth = 1;
    wcount = 0;
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 4'($urandom), 0, 0);
    chk("s7_writes", wcount, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
